// File: rtl/mmio_uart_tx_if.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_if
//   Data-memory port bundle shared by the core's store/load path and the
//   memory-mapped UART transmitter.
//
//   we   : store strobe (MemWrite)
//   a    : byte address (DataAdr)
//   wd   : store data (WriteData)
//   rd   : read data returned by the peripheral (combinational)
//   hit  : peripheral claims the current address
//
//   master : the processor side (drives we/a/wd, samples rd/hit)
//   slave  : the peripheral side
// ---------------------------------------------------------------------------
interface mmio_uart_tx_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;

    modport master (output we, a, wd, input  rd, hit);
    modport slave  (input  we, a, wd, output rd, hit);
endinterface

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter living beside dmem. Stores to TXDATA
//   (BASE) queue a byte in a small FIFO; a serial state machine drains the
//   FIFO one frame at a time. Loads from STATUS (BASE+4) return
//   {28'b0, overflow, empty, busy, full}. A store to STATUS clears the sticky
//   overflow flag.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous reset, active high
//     bus    data-memory port (slave): we, a, wd in; rd, hit out
//     tx     serial line, idle high, registered
//     busy   high while a frame is in progress
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [31:0] BASE         = 32'h0000_0080,
    parameter int          DEPTH        = 4,
    parameter int          CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_uart_tx_if.slave        bus,
    output logic                 tx,
    output logic                 busy
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam int CW    = $clog2(CLKS_PER_BIT);

    localparam logic [31:0]      STAT_ADR   = BASE + 32'd4;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CW-1:0]    TIMER_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------
    logic sel_data;
    logic sel_stat;
    logic full;
    logic empty;
    logic overflow_reg;

    assign sel_data = (bus.a[31:2] == BASE[31:2]);
    assign sel_stat = (bus.a[31:2] == STAT_ADR[31:2]);
    assign bus.hit  = (bus.a[31:3] == BASE[31:3]);
    assign bus.rd   = sel_stat ? {28'b0, overflow_reg, empty, busy, full} : 32'b0;

    // Only the low byte of a store and the word-aligned address bits matter.
    logic unused_bits;
    assign unused_bits = ^{bus.wd[31:8], bus.a[1:0]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             ovf_clr;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    // full is the pre-edge value, so a store into a full FIFO is dropped even
    // if the transmitter frees a slot on the same edge.
    assign push    = bus.we & sel_data & ~full;
    assign ovf_set = bus.we & sel_data & full;
    assign ovf_clr = bus.we & sel_stat;

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= bus.wd[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (ovf_set)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serial state machine
    // ------------------------------------------------------------------
    state_t        state_reg,  state_next;
    logic [CW-1:0] timer_reg,  timer_next;
    logic [2:0]    idx_reg,    idx_next;
    logic [7:0]    shift_reg,  shift_next;
    logic          tx_reg,     tx_next;
    logic          timer_last;

    assign timer_last = (timer_reg == TIMER_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        pop        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr_reg];
                    timer_next = '0;
                    state_next = START;
                end
            end
            START: begin
                if (timer_last) begin
                    timer_next = '0;
                    idx_next   = '0;
                    state_next = DATA;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DATA: begin
                if (timer_last) begin
                    timer_next = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    idx_next   = idx_reg + 1'b1;
                    if (idx_reg == 3'd7)
                        state_next = STOP;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            STOP: begin
                if (timer_last) begin
                    timer_next = '0;
                    // Back-to-back: reload straight into START, no idle gap.
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr_reg];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the upcoming state so the line changes
        // cleanly on the same edge as the state.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx   = tx_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Scoreboard bench for mmio_uart_tx. The driver keeps a timestamp-level
//   model (FIFO contents plus the edge at which the transmitter can next
//   take a byte); every byte the model says is popped is queued together
//   with the edge its start bit must begin on. An independent monitor
//   decodes the serial line and checks each received frame against the
//   queue.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;
    localparam logic [31:0] TB_BASE = 32'h0000_0080;
    localparam logic [31:0] TB_STAT = TB_BASE + 32'd4;
    localparam int          TB_DEPTH = 4;
    localparam int          TB_CPB   = 4;
    localparam int          FRAME    = 10 * TB_CPB;

    typedef struct {
        logic [7:0] b;
        int         start;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic busy;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE         (TB_BASE),
        .DEPTH        (TB_DEPTH),
        .CLKS_PER_BIT (TB_CPB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] mfifo[$];
    frame_t     exp_q[$];
    bit         movf;
    int         next_pop_edge;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_no);
        end
    endfunction

    function automatic void model_reset();
        mfifo.delete();
        exp_q.delete();
        movf          = 1'b0;
        next_pop_edge = 0;
    endfunction

    // One bus cycle: drive inputs, advance the model across the coming edge,
    // then check the registered/combinational outputs just after the edge.
    task automatic step(input logic w, input logic [31:0] addr, input logic [31:0] data);
        bit     dhit, shit, pre_full, pre_ne, do_pop, m_busy;
        int     e;
        frame_t f;
        logic [31:0] exp_rd;
        bus.we = w;
        bus.a  = addr;
        bus.wd = data;
        e        = edge_no + 1;
        dhit     = (addr[31:2] == TB_BASE[31:2]);
        shit     = (addr[31:2] == TB_STAT[31:2]);
        pre_full = (mfifo.size() == TB_DEPTH);
        pre_ne   = (mfifo.size() != 0);
        do_pop   = pre_ne && (e >= next_pop_edge);
        if (do_pop) begin
            f.b   = mfifo.pop_front();
            f.start = e;
            exp_q.push_back(f);
            next_pop_edge = e + FRAME;
        end
        if (w && dhit) begin
            if (pre_full) begin
                movf = 1'b1;
                $display("store a=%h wd=%h -> dropped (FIFO full)", addr, data);
            end else begin
                mfifo.push_back(data[7:0]);
                $display("store a=%h wd=%h -> queued byte %h", addr, data, data[7:0]);
            end
        end else if (w && shit) begin
            movf = 1'b0;
            $display("store a=%h wd=%h -> status write", addr, data);
        end else if (w) begin
            $display("store a=%h wd=%h -> outside window", addr, data);
        end
        @(posedge clk);
        #1;
        m_busy = (e < next_pop_edge);
        check("busy", {31'b0, busy}, {31'b0, m_busy});
        if (!m_busy)
            check("tx_idle", {31'b0, tx}, 32'd1);
        check("hit", {31'b0, bus.hit}, {31'b0, (addr[31:3] == TB_BASE[31:3])});
        exp_rd = shit ? {28'b0, movf, (mfifo.size() == 0), m_busy, (mfifo.size() == TB_DEPTH)} : 32'b0;
        check("rd", bus.rd, exp_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, TB_STAT, 32'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((mfifo.size() != 0 || edge_no + 1 < next_pop_edge) && guard < 2000) begin
            step(1'b0, TB_STAT, 32'b0);
            guard++;
        end
        if (guard >= 2000)
            check("drain_timeout", 32'(guard), 32'd0);
        idle(5);
    endtask

    // Monitor: decode 8N1 frames from the line, mid-bit sampling.
    initial begin : monitor
        bit         in_frame;
        int         start;
        int         k;
        logic [7:0] got;
        frame_t     f;
        in_frame = 1'b0;
        start    = 0;
        got      = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    start    = edge_no;
                    got      = '0;
                end
            end else begin
                k = edge_no - start;
                if (k == 2)
                    check("start_bit", {31'b0, tx}, 32'd0);
                else if (k >= 6 && k <= 34 && (k % 4) == 2)
                    got = {tx, got[7:1]};
                else if (k == 38)
                    check("stop_bit", {31'b0, tx}, 32'd1);
                else if (k == FRAME - 1) begin
                    in_frame = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'b0, got}, 32'hFFFF_FFFF);
                    end else begin
                        f = exp_q.pop_front();
                        $display("frame received %h starting edge %0d", got, start);
                        check("frame_data", {24'b0, got}, {24'b0, f.b});
                        check("frame_start", 32'(start), 32'(f.start));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int addrs[8];
        int sel;
        addrs = '{32'h80, 32'h81, 32'h83, 32'h84, 32'h86, 32'h64, 32'h88, 32'h7C};
        bus.we = 1'b0;
        bus.a  = 32'b0;
        bus.wd = 32'b0;
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);

        // Idle after reset: STATUS must read empty only.
        idle(20);

        // Single byte A5.
        step(1'b1, 32'h80, 32'h0000_00A5);
        drain();

        // Three back-to-back frames.
        step(1'b1, 32'h80, 32'h11);
        step(1'b1, 32'h80, 32'h22);
        step(1'b1, 32'h80, 32'h33);
        drain();

        // Overflow: six consecutive stores, then clear via STATUS store.
        for (int i = 0; i < 6; i++)
            step(1'b1, 32'h80, 32'hC0 + 32'(i));
        step(1'b0, TB_STAT, 32'b0);
        step(1'b1, TB_STAT, 32'hDEAD_BEEF);
        drain();

        // Reset in the middle of the second queued frame's data bits.
        step(1'b1, 32'h80, 32'h5A);
        step(1'b1, 32'h80, 32'h3C);
        idle(55);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_tx", {31'b0, tx}, 32'd1);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_status", bus.rd, 32'h4);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(60);

        // Outside the window, and an unaligned TXDATA address.
        step(1'b1, 32'h64, 32'h77);
        step(1'b1, 32'h88, 32'h78);
        idle(3);
        step(1'b1, 32'h83, 32'h1234_5699);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                sel = $urandom_range(0, 7);
                step(1'($urandom_range(0, 3) != 0), 32'(addrs[sel]), $urandom);
            end else begin
                idle($urandom_range(1, 60));
            end
        end
        drain();

        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
